// File: rtl/mem_stage_pipelined.sv
// mem_stage_pipelined
//   MIPS memory stage with MEM/WB pipeline register. Handles byte/half/word
//   loads (sign or zero extended) and stores with byte enables. Also resolves
//   BEQ/BNE. A data memory with WAIT_STATES extra cycles per access
//   back-pressures the EX/MEM register through in_ready.
//
// Optional feature macro: MEM_STAGE_MISALIGN_TRAP_EN
//   defined   : a misaligned half/word access leaves memory untouched. It
//               completes in one cycle with wb_reg_write forced low and
//               misalign high.
//   undefined : the low address bits are masked to the access alignment,
//               and misalign is tied low.
//
// Handshake: a slot transfers on a cycle where in_valid & in_ready are both
//   high. While in_ready is low, upstream holds every input stable. The
//   stage therefore keeps using the live inputs for the rest of a
//   multi-cycle access.
//
// Ports
//   clk, reset (async, active high)
//   in_valid / in_ready       : EX/MEM slot handshake
//   mem_read, mem_write, mem_size, mem_unsigned : access control
//   branch, branch_ne, alu_zero, add_result     : branch resolution
//   alu_result, write_data    : address / ALU result, store data
//   dest_reg, reg_write, mem_to_reg             : writeback control
//   pc_src, branch_target     : to fetch
//   wb_*                      : MEM/WB register outputs
//   misalign                  : misaligned-access flag (trap build only)
module mem_stage_pipelined #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic              branch,
  input  logic              branch_ne,
  input  logic              alu_zero,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] add_result,
  input  logic [4:0]        dest_reg,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  output logic              pc_src,
  output logic [DATA_W-1:0] branch_target,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [4:0]        wb_dest_reg,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic              misalign
);

  localparam int AW = $clog2(DEPTH);
  localparam logic       HAS_WAIT = (WAIT_STATES != 0);
  localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  // FSM state bundled for observation; the control logic reads it from here.
  typedef struct packed {
    state_t     state;
    logic [2:0] cnt;
  } dbg_t;

  state_t            state_q;
  logic [2:0]        cnt_q;
  dbg_t              dbg;

  logic              wb_valid_q, wb_reg_write_q, wb_mem_to_reg_q, misalign_q;
  logic [4:0]        wb_dest_reg_q;
  logic [DATA_W-1:0] wb_read_data_q, wb_alu_result_q;
  logic [DATA_W-1:0] wb_read_data_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept, is_mem, is_load, misal;
  logic              sz_byte, sz_half, sz_word;
  logic              start_busy, busy_done, complete, mem_we;
  logic [1:0]        lane;
  logic [AW-1:0]     word_idx;
  logic [DATA_W-1:0] rd_word, wword, ld_ext;
  logic [3:0]        be;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  assign dbg = '{state: state_q, cnt: cnt_q};

  // ---------------------------------------------------------------- control
  assign in_ready = (dbg.state == S_IDLE);
  assign accept   = in_valid & in_ready;
  assign is_mem   = mem_read | mem_write;
  // Read and write together behave as a store.
  assign is_load  = mem_read & ~mem_write;

  assign sz_byte  = (mem_size == 2'b00);
  assign sz_half  = (mem_size == 2'b01);
  assign sz_word  = ~sz_byte & ~sz_half;   // 10 and reserved 11

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign misal = is_mem & ((sz_half & alu_result[0]) |
                           (sz_word & (alu_result[1:0] != 2'b00)));
`else
  assign misal = 1'b0;
`endif

  assign pc_src        = accept & branch & (alu_zero ^ branch_ne);
  assign branch_target = add_result;

  // A multi-cycle access starts only for an aligned memory op with wait states;
  // everything else completes on its accept edge.
  assign start_busy = accept & is_mem & ~misal & HAS_WAIT;
  assign busy_done  = (dbg.state == S_BUSY) & (dbg.cnt == 3'd0);
  assign complete   = (accept & ~start_busy) | busy_done;
  assign mem_we     = complete & mem_write & ~misal;

  // ------------------------------------------------------- address / lanes
  assign word_idx = alu_result[AW+1:2];
  // Lane of the lowest byte touched; sub-alignment bits are masked off.
  assign lane = sz_byte ? alu_result[1:0] :
                sz_half ? {alu_result[1], 1'b0} : 2'b00;

  always_comb begin
    be    = 4'b0000;
    wword = write_data;
    if (sz_byte) begin
      be        = 4'b0000;
      be[lane]  = 1'b1;
      wword     = {4{write_data[7:0]}};
    end else if (sz_half) begin
      be    = lane[1] ? 4'b1100 : 4'b0011;
      wword = {2{write_data[15:0]}};
    end else begin
      be    = 4'b1111;
      wword = write_data;
    end
  end

  assign rd_word = mem_q[word_idx];
  assign ld_byte = rd_word[{lane, 3'b000} +: 8];
  assign ld_half = rd_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    ld_ext = rd_word;
    if (sz_byte)
      ld_ext = mem_unsigned ? {{(DATA_W-8){1'b0}}, ld_byte}
                            : {{(DATA_W-8){ld_byte[7]}}, ld_byte};
    else if (sz_half)
      ld_ext = mem_unsigned ? {{(DATA_W-16){1'b0}}, ld_half}
                            : {{(DATA_W-16){ld_half[15]}}, ld_half};
  end

  assign wb_read_data_d = (is_load & ~misal) ? ld_ext : '0;

  // ------------------------------------------------------------ data memory
  // Not reset. The write is also gated by reset so that an access
  // aborted by reset never commits.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[word_idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------- FSM + MEM/WB register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= 3'd0;
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_dest_reg_q   <= 5'd0;
      wb_read_data_q  <= '0;
      wb_alu_result_q <= '0;
      misalign_q      <= 1'b0;
    end else begin
      wb_valid_q <= complete;
      misalign_q <= complete & misal;
      if (complete) begin
        wb_reg_write_q  <= reg_write & ~misal;
        wb_mem_to_reg_q <= mem_to_reg;
        wb_dest_reg_q   <= dest_reg;
        wb_read_data_q  <= wb_read_data_d;
        wb_alu_result_q <= alu_result;
      end
      case (state_q)
        S_IDLE: begin
          if (start_busy) begin
            state_q <= S_BUSY;
            cnt_q   <= CNT_INIT;
          end
        end
        S_BUSY: begin
          if (cnt_q == 3'd0) state_q <= S_IDLE;
          else               cnt_q   <= cnt_q - 3'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign wb_dest_reg   = wb_dest_reg_q;
  assign wb_read_data  = wb_read_data_q;
  assign wb_alu_result = wb_alu_result_q;
  assign misalign      = misalign_q;

endmodule

// File: tb/tb_mem_stage_pipelined.sv
// Testbench for mem_stage_pipelined. Two instances are used: one with no
// wait states (u0) and one with three wait states (u3).
module tb_mem_stage_pipelined;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int AW     = 8;

  // ------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        in_valid;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        branch;
    logic        branch_ne;
    logic        alu_zero;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] add_result;
    logic [4:0]  dest_reg;
    logic        reg_write;
    logic        mem_to_reg;
  } in_t;

  typedef struct {
    in_t         in;
    logic [31:0] rdata;
    logic        pc;
    logic        rw;
    logic        mis;
  } vec_t;

  in_t i0, i3;

  logic        o0_in_ready, o0_pc_src, o0_wb_valid, o0_wb_reg_write, o0_wb_mem_to_reg, o0_misalign;
  logic [31:0] o0_branch_target, o0_wb_read_data, o0_wb_alu_result;
  logic [4:0]  o0_wb_dest_reg;
  logic        o3_in_ready, o3_pc_src, o3_wb_valid, o3_wb_reg_write, o3_wb_mem_to_reg, o3_misalign;
  logic [31:0] o3_branch_target, o3_wb_read_data, o3_wb_alu_result;
  logic [4:0]  o3_wb_dest_reg;

  mem_stage_pipelined #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_STATES(0)) u0 (
    .clk(clk), .reset(reset),
    .in_valid(i0.in_valid), .in_ready(o0_in_ready),
    .mem_read(i0.mem_read), .mem_write(i0.mem_write), .mem_size(i0.mem_size),
    .mem_unsigned(i0.mem_unsigned), .branch(i0.branch), .branch_ne(i0.branch_ne),
    .alu_zero(i0.alu_zero), .alu_result(i0.alu_result), .write_data(i0.write_data),
    .add_result(i0.add_result), .dest_reg(i0.dest_reg), .reg_write(i0.reg_write),
    .mem_to_reg(i0.mem_to_reg), .pc_src(o0_pc_src), .branch_target(o0_branch_target),
    .wb_valid(o0_wb_valid), .wb_reg_write(o0_wb_reg_write), .wb_mem_to_reg(o0_wb_mem_to_reg),
    .wb_dest_reg(o0_wb_dest_reg), .wb_read_data(o0_wb_read_data),
    .wb_alu_result(o0_wb_alu_result), .misalign(o0_misalign)
  );

  mem_stage_pipelined #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_STATES(3)) u3 (
    .clk(clk), .reset(reset),
    .in_valid(i3.in_valid), .in_ready(o3_in_ready),
    .mem_read(i3.mem_read), .mem_write(i3.mem_write), .mem_size(i3.mem_size),
    .mem_unsigned(i3.mem_unsigned), .branch(i3.branch), .branch_ne(i3.branch_ne),
    .alu_zero(i3.alu_zero), .alu_result(i3.alu_result), .write_data(i3.write_data),
    .add_result(i3.add_result), .dest_reg(i3.dest_reg), .reg_write(i3.reg_write),
    .mem_to_reg(i3.mem_to_reg), .pc_src(o3_pc_src), .branch_target(o3_branch_target),
    .wb_valid(o3_wb_valid), .wb_reg_write(o3_wb_reg_write), .wb_mem_to_reg(o3_wb_mem_to_reg),
    .wb_dest_reg(o3_wb_dest_reg), .wb_read_data(o3_wb_read_data),
    .wb_alu_result(o3_wb_alu_result), .misalign(o3_misalign)
  );

  // ------------------------------------------------------------ scoreboard
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [0:0]  mis_q[$];
  logic [7:0]  ref_mem [DEPTH*4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic in_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic uns, input logic br, input logic bne, input logic z,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] tg,
                             input logic [4:0] d, input logic rw, input logic m2r);
    in_t x;
    x.in_valid = 1'b1; x.mem_read = rd; x.mem_write = wr; x.mem_size = sz;
    x.mem_unsigned = uns; x.branch = br; x.branch_ne = bne; x.alu_zero = z;
    x.alu_result = a; x.write_data = wd; x.add_result = tg; x.dest_reg = d;
    x.reg_write = rw; x.mem_to_reg = m2r;
    return x;
  endfunction

  // Byte-addressed little-endian reference memory.
  task automatic model(input in_t x, output logic [31:0] rd, output logic mis);
    int n;
    int ba;
    logic [31:0] v;
    n   = (x.mem_size == 2'b00) ? 1 : (x.mem_size == 2'b01) ? 2 : 4;
    ba  = int'(x.alu_result[AW+1:0]);
    mis = 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    if ((x.mem_read || x.mem_write) && (ba % n) != 0) mis = 1'b1;
`endif
    ba = ba - (ba % n);
    rd = '0;
    if (!mis && x.mem_write) begin
      for (int k = 0; k < n; k++) ref_mem[ba+k] = x.write_data[8*k +: 8];
    end else if (!mis && x.mem_read) begin
      v = '0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[ba+k];
      if (!x.mem_unsigned && n < 4 && v[8*n-1])
        for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
      rd = v;
    end
  endtask

  // Multi-cycle access on the wait-state instance; called at posedge+1.
  task automatic op3(input string nm, input in_t x, input logic exp_pc, input logic [31:0] exp_rd);
    x.in_valid = 1'b1;
    i3 = x;
    #1;
    chk({nm, " ready_at_accept"}, o3_in_ready, 1);
    chk({nm, " pc_src_at_accept"}, o3_pc_src, exp_pc);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k < 4) begin
        chk({nm, " ready_low_busy"}, o3_in_ready, 0);
        chk({nm, " wb_valid_low_busy"}, o3_wb_valid, 0);
        chk({nm, " pc_src_low_busy"}, o3_pc_src, 0);
      end
    end
    chk({nm, " wb_valid_at_t4"}, o3_wb_valid, 1);
    chk({nm, " rdata"}, o3_wb_read_data, exp_rd);
    chk({nm, " ready_back"}, o3_in_ready, 1);
    i3.in_valid = 1'b0;
    @(posedge clk); #1;
    chk({nm, " wb_valid_single_pulse"}, o3_wb_valid, 0);
  endtask

  vec_t tbl[28];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------- test
  initial begin
    logic [31:0] erd, dut_rd;
    logic        emis;
    in_t         x;
    logic [31:0] last_rd;

    // Vector table for the zero-wait instance: {inputs, rdata, pc_src, reg_write, misalign}.
    tbl[0]  = '{mk(0,1,2'd2,0,0,0,0,32'h10,32'hDEADBEEF,32'h100,5'd0,0,0), 32'h0, 0, 0, 0};
    tbl[1]  = '{mk(1,0,2'd2,0,0,0,0,32'h10,32'h0,32'h104,5'd8,1,1), 32'hDEADBEEF, 0, 1, 0};
    tbl[2]  = '{mk(0,1,2'd2,0,0,0,0,32'h10,32'h0,32'h0,5'd0,0,0), 32'h0, 0, 0, 0};
    tbl[3]  = '{mk(0,1,2'd0,0,0,0,0,32'h13,32'h12345680,32'h0,5'd0,0,0), 32'h0, 0, 0, 0};
    tbl[4]  = '{mk(1,0,2'd0,0,0,0,0,32'h13,32'h0,32'h0,5'd9,1,1), 32'hFFFFFF80, 0, 1, 0};
    tbl[5]  = '{mk(1,0,2'd0,1,0,0,0,32'h13,32'h0,32'h0,5'd10,1,1), 32'h00000080, 0, 1, 0};
    tbl[6]  = '{mk(1,0,2'd2,0,0,0,0,32'h10,32'h0,32'h0,5'd11,1,1), 32'h80000000, 0, 1, 0};
    tbl[7]  = '{mk(0,1,2'd2,0,0,0,0,32'h14,32'h11223344,32'h0,5'd0,0,0), 32'h0, 0, 0, 0};
    tbl[8]  = '{mk(0,1,2'd1,0,0,0,0,32'h16,32'h7777A5A5,32'h0,5'd0,0,0), 32'h0, 0, 0, 0};
    tbl[9]  = '{mk(1,0,2'd1,0,0,0,0,32'h16,32'h0,32'h0,5'd12,1,1), 32'hFFFFA5A5, 0, 1, 0};
    tbl[10] = '{mk(1,0,2'd1,1,0,0,0,32'h16,32'h0,32'h0,5'd13,1,1), 32'h0000A5A5, 0, 1, 0};
    tbl[11] = '{mk(1,0,2'd0,0,0,0,0,32'h14,32'h0,32'h0,5'd14,1,1), 32'h00000044, 0, 1, 0};
    tbl[12] = '{mk(1,0,2'd0,0,0,0,0,32'h15,32'h0,32'h0,5'd15,1,1), 32'h00000033, 0, 1, 0};
    tbl[13] = '{mk(1,0,2'd2,0,0,0,0,32'h14,32'h0,32'h0,5'd16,1,1), 32'hA5A53344, 0, 1, 0};
    tbl[14] = '{mk(0,0,2'd0,0,1,0,1,32'h0,32'h0,32'h400,5'd0,0,0), 32'h0, 1, 0, 0};
    tbl[15] = '{mk(0,0,2'd0,0,1,1,1,32'h0,32'h0,32'h404,5'd0,0,0), 32'h0, 0, 0, 0};
    tbl[16] = '{mk(0,0,2'd0,0,1,1,0,32'h7,32'h0,32'h408,5'd0,0,0), 32'h0, 1, 0, 0};
    tbl[17] = '{mk(0,0,2'd0,0,1,0,0,32'h7,32'h0,32'h40C,5'd0,0,0), 32'h0, 0, 0, 0};
    tbl[18] = '{mk(0,0,2'd0,0,0,0,0,32'h5A5A0001,32'h0,32'h0,5'd31,1,0), 32'h0, 0, 1, 0};
    tbl[19] = '{mk(1,1,2'd2,0,0,0,0,32'h18,32'hCAFEF00D,32'h0,5'd3,0,0), 32'h0, 0, 0, 0};
    tbl[20] = '{mk(1,0,2'd3,0,0,0,0,32'h18,32'h0,32'h0,5'd4,1,1), 32'hCAFEF00D, 0, 1, 0};
    tbl[21] = '{mk(1,0,2'd2,0,0,0,0,32'h418,32'h0,32'h0,5'd5,1,1), 32'hCAFEF00D, 0, 1, 0};
    tbl[22] = '{mk(0,1,2'd2,0,0,0,0,32'h20,32'h0BADC0DE,32'h0,5'd0,0,0), 32'h0, 0, 0, 0};
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    tbl[23] = '{mk(1,0,2'd2,0,0,0,0,32'h22,32'h0,32'h0,5'd6,1,1), 32'h0, 0, 0, 1};
    tbl[24] = '{mk(1,0,2'd2,0,0,0,0,32'h20,32'h0,32'h0,5'd7,1,1), 32'h0BADC0DE, 0, 1, 0};
    tbl[25] = '{mk(0,1,2'd1,0,0,0,0,32'h21,32'h0000FFFF,32'h0,5'd0,0,0), 32'h0, 0, 0, 1};
    tbl[26] = '{mk(1,0,2'd2,0,0,0,0,32'h20,32'h0,32'h0,5'd17,1,1), 32'h0BADC0DE, 0, 1, 0};
    tbl[27] = '{mk(1,0,2'd1,1,0,0,0,32'h23,32'h0,32'h0,5'd18,1,1), 32'h0, 0, 0, 1};
`else
    tbl[23] = '{mk(1,0,2'd2,0,0,0,0,32'h22,32'h0,32'h0,5'd6,1,1), 32'h0BADC0DE, 0, 1, 0};
    tbl[24] = '{mk(1,0,2'd2,0,0,0,0,32'h20,32'h0,32'h0,5'd7,1,1), 32'h0BADC0DE, 0, 1, 0};
    tbl[25] = '{mk(0,1,2'd1,0,0,0,0,32'h21,32'h0000FFFF,32'h0,5'd0,0,0), 32'h0, 0, 0, 0};
    tbl[26] = '{mk(1,0,2'd2,0,0,0,0,32'h20,32'h0,32'h0,5'd17,1,1), 32'h0BADFFFF, 0, 1, 0};
    tbl[27] = '{mk(1,0,2'd1,1,0,0,0,32'h23,32'h0,32'h0,5'd18,1,1), 32'h00000BAD, 0, 1, 0};
`endif

    // Reset state.
    reset = 1'b1;
    i0 = '0;
    i3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst u0 wb_valid", o0_wb_valid, 0);
    chk("rst u0 wb_read_data", o0_wb_read_data, 0);
    chk("rst u0 wb_alu_result", o0_wb_alu_result, 0);
    chk("rst u0 wb_dest_reg", o0_wb_dest_reg, 0);
    chk("rst u0 wb_reg_write", o0_wb_reg_write, 0);
    chk("rst u0 wb_mem_to_reg", o0_wb_mem_to_reg, 0);
    chk("rst u0 misalign", o0_misalign, 0);
    chk("rst u3 wb_valid", o3_wb_valid, 0);
    chk("rst u3 misalign", o3_misalign, 0);
    chk("rst u3 in_ready", o3_in_ready, 1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Table-driven, back to back on the zero-wait instance.
    for (int k = 0; k < 28; k++) begin
      i0 = tbl[k].in;
      #1;
      chk($sformatf("v%0d in_ready", k), o0_in_ready, 1);
      chk($sformatf("v%0d pc_src", k), o0_pc_src, tbl[k].pc);
      chk($sformatf("v%0d branch_target", k), o0_branch_target, tbl[k].in.add_result);
      @(posedge clk); #1;
      chk($sformatf("v%0d wb_valid", k), o0_wb_valid, 1);
      chk($sformatf("v%0d wb_read_data", k), o0_wb_read_data, tbl[k].rdata);
      chk($sformatf("v%0d wb_alu_result", k), o0_wb_alu_result, tbl[k].in.alu_result);
      chk($sformatf("v%0d wb_dest_reg", k), o0_wb_dest_reg, tbl[k].in.dest_reg);
      chk($sformatf("v%0d wb_reg_write", k), o0_wb_reg_write, tbl[k].rw);
      chk($sformatf("v%0d wb_mem_to_reg", k), o0_wb_mem_to_reg, tbl[k].in.mem_to_reg);
      chk($sformatf("v%0d misalign", k), o0_misalign, tbl[k].mis);
    end
    last_rd = tbl[27].rdata;
    i0.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle wb_valid", o0_wb_valid, 0);
    chk("idle misalign", o0_misalign, 0);
    chk("idle wb_read_data hold", o0_wb_read_data, last_rd);
    chk("idle wb_dest_reg hold", o0_wb_dest_reg, tbl[27].in.dest_reg);

    // Random phase: initialise words 0x100..0x1FC, then mixed random ops.
    for (int w = 0; w < 64; w++) begin
      x = mk(0,1,2'd2,0,0,0,0, 32'h100 + 32'(w*4), $urandom, 32'h0, 5'd0, 0, 0);
      model(x, erd, emis);
      i0 = x;
      @(posedge clk); #1;
    end
    i0.in_valid = 1'b0;
    @(posedge clk); #1;
    for (int n = 0; n < 80; n++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a = ($urandom & 32'hFFFFFC00) | (32'h100 + 32'($urandom_range(0, 255)));
      x = mk(kind < 2, kind >= 2, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             0, 0, 0, a, $urandom, 32'h0, 5'($urandom_range(0, 31)), 1, kind < 2);
      model(x, erd, emis);
      exp_q.push_back(erd);
      mis_q.push_back(emis);
      i0 = x;
      @(posedge clk); #1;
      chk($sformatf("rnd%0d wb_valid", n), o0_wb_valid, 1);
      dut_rd = exp_q.pop_front();
      chk($sformatf("rnd%0d wb_read_data", n), o0_wb_read_data, dut_rd);
      chk($sformatf("rnd%0d misalign", n), o0_misalign, 32'(mis_q.pop_front()));
    end
    i0.in_valid = 1'b0;
    chk("scoreboard drained", 32'(exp_q.size()), 0);
    @(posedge clk); #1;

    // Wait-state instance.
    op3("sw3", mk(0,1,2'd2,0,0,0,0,32'h20,32'hAAAA5555,32'h0,5'd0,0,0), 0, 32'h0);
    op3("lw3", mk(1,0,2'd2,0,1,0,1,32'h20,32'h0,32'h80,5'd2,1,1), 1, 32'hAAAA5555);
    chk("lw3 wb_alu_result", o3_wb_alu_result, 32'h20);

    // Non-memory op on the wait-state instance keeps one-cycle latency.
    i3 = mk(0,0,2'd0,0,0,0,0,32'h00C0FFEE,32'h0,32'h0,5'd21,1,0);
    #1;
    chk("alu3 in_ready", o3_in_ready, 1);
    @(posedge clk); #1;
    chk("alu3 wb_valid", o3_wb_valid, 1);
    chk("alu3 wb_alu_result", o3_wb_alu_result, 32'h00C0FFEE);
    chk("alu3 in_ready after", o3_in_ready, 1);
    i3.in_valid = 1'b0;
    @(posedge clk); #1;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    i3 = mk(1,0,2'd2,0,0,0,0,32'h22,32'h0,32'h0,5'd22,1,1);
    #1;
    @(posedge clk); #1;
    chk("mis3 wb_valid", o3_wb_valid, 1);
    chk("mis3 misalign", o3_misalign, 1);
    chk("mis3 wb_reg_write", o3_wb_reg_write, 0);
    chk("mis3 in_ready", o3_in_ready, 1);
    i3.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mis3 misalign drop", o3_misalign, 0);
    op3("lw3 after trap", mk(1,0,2'd2,0,0,0,0,32'h20,32'h0,32'h0,5'd2,1,1), 0, 32'hAAAA5555);
`else
    op3("lw3 @22", mk(1,0,2'd2,0,0,0,0,32'h22,32'h0,32'h0,5'd2,1,1), 0, 32'hAAAA5555);
`endif

    // Reset in the second BUSY cycle aborts the store.
    i3 = mk(0,1,2'd2,0,0,0,0,32'h20,32'h12345678,32'h0,5'd1,0,0);
    #1;
    chk("rstbusy accept", o3_in_ready, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstbusy busy before reset", o3_in_ready, 0);
    reset = 1'b1;
    #1;
    chk("rstbusy wb_valid", o3_wb_valid, 0);
    chk("rstbusy wb_alu_result", o3_wb_alu_result, 0);
    chk("rstbusy wb_read_data", o3_wb_read_data, 0);
    chk("rstbusy wb_dest_reg", o3_wb_dest_reg, 0);
    chk("rstbusy idle", o3_in_ready, 1);
    i3.in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    op3("lw3 after abort", mk(1,0,2'd2,0,0,0,0,32'h20,32'h0,32'h0,5'd2,1,1), 0, 32'hAAAA5555);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
